// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial fixed-pattern detector with match pulse and match counter
//
// Consumes one serial bit per clock while en=1.
// Flags every occurrence of PATTERN with a one-cycle pulse on match.
// Counts matches on match_cnt.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         bit-valid; d is sampled only when en=1
//   d          serial data bit
//   window     last PAT_W accepted bits, newest in LSB
//   fill       accepted bits since reset/clear, saturates at PAT_W
//   match      registered 1-cycle pulse on pattern hit
//   match_cnt  wrapping count of matches since reset
//
// Build option SEQ_DET_NONOVERLAP_EN:
//   When defined, a hit clears fill, so the next hit needs PAT_W fresh bits.
//   When undefined, detection overlaps.

module seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  output logic [PAT_W-1:0] window,
  output logic [4:0]       fill,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [4:0]       FILL_MAX = 5'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PAT_W-1:0] window_next;
  logic [4:0]       fill_inc;
  logic             hit;

  assign window_next = {window[PAT_W-2:0], d};
  assign fill_inc    = fill + 5'd1;

  // The fill guard keeps the reset-zero window from combining with the first
  // few bits into a false hit (matters for patterns with leading zeros).
  assign hit = en && (window_next == PATTERN) && (fill_inc >= FILL_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window    <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;
      if (en) begin
        window <= window_next;
`ifdef SEQ_DET_NONOVERLAP_EN
        if (hit) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill_inc;
        end
`else
        if (fill != FILL_MAX) begin
          fill <= fill_inc;
        end
`endif
      end
      if (hit) begin
        match_cnt <= match_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - randomized self-checking bench for seq_detector

module tb_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, d;

  logic [3:0] win_a, win_b;
  logic [4:0] fill_a, fill_b;
  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  // Instance a: default parameters (PATTERN 1011, 8-bit counter)
  seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d),
    .window(win_a), .fill(fill_a), .match(match_a), .match_cnt(cnt_a)
  );

  // Instance b: leading-zero pattern and 2-bit counter for guard/wrap cases
  seq_detector #(.PAT_W(4), .PATTERN(4'b0001), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d),
    .window(win_b), .fill(fill_b), .match(match_b), .match_cnt(cnt_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer arithmetic on the accepted bit history
  int pat[2]  = '{11, 1};
  int modv[2] = '{256, 4};
  int wv[2];     // value of last 4 accepted bits
  int run[2];    // accepted bits since reset or non-overlap clear
  int cnt[2];
  int mexp[2];

  task automatic model_step(input int k, input logic r, input logic e, input logic b);
    if (!r) begin
      wv[k] = 0; run[k] = 0; cnt[k] = 0; mexp[k] = 0;
    end else if (e) begin
      wv[k]  = (wv[k] * 2 + int'(b)) % 16;
      run[k] = run[k] + 1;
      mexp[k] = (run[k] >= 4 && wv[k] == pat[k]) ? 1 : 0;
      if (mexp[k] == 1) begin
        cnt[k] = (cnt[k] + 1) % modv[k];
`ifdef SEQ_DET_NONOVERLAP_EN
        run[k] = 0;
`endif
      end
    end else begin
      mexp[k] = 0;
    end
  endtask

  function automatic int fill_of(input int r);
    return (r > 4) ? 4 : r;
  endfunction

  function automatic logic [29:0] exp_vec();
    return {4'(wv[0]), 5'(fill_of(run[0])), 1'(mexp[0]), 8'(cnt[0]),
            4'(wv[1]), 5'(fill_of(run[1])), 1'(mexp[1]), 2'(cnt[1])};
  endfunction

  function automatic logic [29:0] obs_vec();
    return {win_a, fill_a, match_a, cnt_a, win_b, fill_b, match_b, cnt_b};
  endfunction

  task automatic apply(input logic r, input logic e, input logic b);
    rst_n = r; en = e; d = b;
    @(posedge clk);
    model_step(0, r, e, b);
    model_step(1, r, e, b);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1);
    vectors++;
    if ({win_a, fill_a, match_a, cnt_a} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_a got=%h want=0", {win_a, fill_a, match_a, cnt_a});
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    int pulses = 0;
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      apply(1'b1, 1'b1, s[i]);
      if (match_a === 1'b1) pulses++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL overlap_bit%0d got=%h want=%h", 7 - i, obs_vec(), exp_vec());
      end
    end
`ifdef SEQ_DET_NONOVERLAP_EN
    vectors++;
    if (pulses != 1 || cnt_a !== 8'd1 || fill_a !== 5'd3) begin
      miscompares++;
      $display("FAIL nonoverlap_end pulses=%0d cnt=%0d fill=%0d want 1/1/3", pulses, cnt_a, fill_a);
    end
`else
    vectors++;
    if (pulses != 2 || cnt_a !== 8'd2 || win_a !== 4'b1011) begin
      miscompares++;
      $display("FAIL overlap_end pulses=%0d cnt=%0d win=%b want 2/2/1011", pulses, cnt_a, win_a);
    end
`endif
  endtask

  task automatic test_gating();
    logic [3:0] s = 4'b1011;
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      apply(1'b1, 1'b1, s[i]);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL gating_bit got=%h want=%h", obs_vec(), exp_vec());
      end
      apply(1'b1, 1'b0, 1'($urandom_range(1)));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL gating_idle got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (match_a !== 1'b0 || win_a !== 4'b1011 || cnt_a !== 8'd1) begin
      miscompares++;
      $display("FAIL gating_end match=%b win=%b cnt=%0d want 0/1011/1", match_a, win_a, cnt_a);
    end
  endtask

  task automatic test_early_guard();
    logic [3:0] s = 4'b0001;
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    vectors++;
    if (match_b !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL guard_first got=%h want=%h", obs_vec(), exp_vec());
    end
    for (int i = 3; i >= 0; i--) begin
      apply(1'b1, 1'b1, s[i]);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL guard_run got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (match_b !== 1'b1 || cnt_b !== 2'd1) begin
      miscompares++;
      $display("FAIL guard_hit match=%b cnt=%0d want 1/1", match_b, cnt_b);
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1);
    vectors++;
    if (fill_a !== 5'd1 || match_a !== 1'b0 || win_a !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset fill=%0d match=%b win=%b want 1/0/0001", fill_a, match_a, win_a);
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL mid_reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [3:0] s = 4'b0001;
    apply(1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 4; h++) begin
      for (int i = 3; i >= 0; i--) begin
        apply(1'b1, 1'b1, s[i]);
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_hit%0d got=%h want=%h", h, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (cnt_b !== 2'd0 || match_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_end cnt=%0d match=%b want 0/1", cnt_b, match_b);
    end
  endtask

  task automatic test_random();
    apply(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      apply(($urandom % 60) != 0, ($urandom % 4) != 0, 1'($urandom_range(1)));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; d = 1'b0;
    test_reset();
    test_overlap();
    test_gating();
    test_early_guard();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
